// File: rtl/instr_adr_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : instr_adr_seq_pkg
//  Description : Shared types and constants for the instruction address
//                sequencer and its redirect selector.
//  Revision    : 1.0 - initial release
// ============================================================================
package instr_adr_seq_pkg;

    localparam int c_word_length = 32;
    localparam int c_instr_bytes = 4;

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_RUN   = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_FD   = 2'd1,
        SRC_OF   = 2'd2,
        SRC_EX   = 2'd3
    } src_t;

endpackage
`default_nettype wire

// File: rtl/instr_adr_sel.sv
`default_nettype none
// ============================================================================
//  Module      : instr_adr_sel
//  Description : Combinational fixed-priority (EX > OF > FD) redirect mux
//                returning the winner, its aligned target and flush bits.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_adr_sel
    import instr_adr_seq_pkg::*;
#(
    parameter int WORD_LENGTH = c_word_length
) (
    input  logic                   i_fd_redirect,
    input  logic [WORD_LENGTH-1:0] i_fd_pstate0,
    input  logic [WORD_LENGTH-1:0] i_fd_pstate1,
    input  logic                   i_of_redirect,
    input  logic [WORD_LENGTH-1:0] i_of_pstate0,
    input  logic [WORD_LENGTH-1:0] i_of_pstate1,
    input  logic                   i_ex_redirect,
    input  logic [WORD_LENGTH-1:0] i_ex_pstate0,
    input  logic [WORD_LENGTH-1:0] i_ex_pstate1,
    output src_t                   o_src,
    output logic [WORD_LENGTH-1:0] o_target0,
    output logic [WORD_LENGTH-1:0] o_target1,
    output logic                   o_flush_fd,
    output logic                   o_flush_of
);

    always_comb begin
        o_src      = SRC_NONE;
        o_target0  = '0;
        o_target1  = '0;
        o_flush_fd = 1'b0;
        o_flush_of = 1'b0;
        if (i_ex_redirect) begin
            o_src      = SRC_EX;
            o_target0  = i_ex_pstate0;
            o_target1  = i_ex_pstate1;
            o_flush_fd = 1'b1;
            o_flush_of = 1'b1;
        end else if (i_of_redirect) begin
            o_src      = SRC_OF;
            o_target0  = i_of_pstate0;
            o_target1  = i_of_pstate1;
            o_flush_fd = 1'b1;
        end else if (i_fd_redirect) begin
            o_src      = SRC_FD;
            o_target0  = i_fd_pstate0;
            o_target1  = i_fd_pstate1;
        end
        // Instruction offsets are word aligned; drop any stray low bits.
        o_target1[1:0] = 2'b00;
    end

endmodule
`default_nettype wire

// File: rtl/instr_adr_seq.sv
`default_nettype none
// ============================================================================
//  Module      : instr_adr_seq
//  Description : Next-instruction-address sequencer owning pstate0/pstate1,
//                with prioritised redirects, flushes, halt and event count.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_adr_seq
    import instr_adr_seq_pkg::*;
#(
    parameter int                     WORD_LENGTH   = c_word_length,
    parameter logic [WORD_LENGTH-1:0] RESET_PSTATE0 = '0,
    parameter logic [WORD_LENGTH-1:0] RESET_PSTATE1 = '0,
    parameter int                     INSTR_BYTES   = c_instr_bytes,
    parameter int                     CNT_WIDTH     = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   inHalt,
    input  logic                   inFdReady,
    input  logic                   inFdRedirect,
    input  logic [WORD_LENGTH-1:0] inFdPstate0,
    input  logic [WORD_LENGTH-1:0] inFdPstate1,
    input  logic                   inOfRedirect,
    input  logic [WORD_LENGTH-1:0] inOfPstate0,
    input  logic [WORD_LENGTH-1:0] inOfPstate1,
    input  logic                   inExRedirect,
    input  logic [WORD_LENGTH-1:0] inExPstate0,
    input  logic [WORD_LENGTH-1:0] inExPstate1,
    output logic                   outValid,
    output logic [WORD_LENGTH-1:0] outPstate0,
    output logic [WORD_LENGTH-1:0] outPstate1,
    output logic                   outFlushFd,
    output logic                   outFlushOf,
    output logic                   outHalted,
    output logic [CNT_WIDTH-1:0]   outRedirectCnt
);

    state_t                 r_state, w_state_nxt;
    logic [WORD_LENGTH-1:0] r_pc0, r_pc1, w_pc0_nxt, w_pc1_nxt;
    logic [CNT_WIDTH-1:0]   r_cnt, w_cnt_nxt;

    src_t                   w_src;
    logic [WORD_LENGTH-1:0] w_tgt0, w_tgt1;
    logic                   w_sel_flush_fd, w_sel_flush_of;
    logic                   w_any, w_active, w_transfer;
    logic                   w_valid, w_halted, w_flush_fd, w_flush_of;

    instr_adr_sel #(
        .WORD_LENGTH (WORD_LENGTH)
    ) u_sel (
        .i_fd_redirect (inFdRedirect),
        .i_fd_pstate0  (inFdPstate0),
        .i_fd_pstate1  (inFdPstate1),
        .i_of_redirect (inOfRedirect),
        .i_of_pstate0  (inOfPstate0),
        .i_of_pstate1  (inOfPstate1),
        .i_ex_redirect (inExRedirect),
        .i_ex_pstate0  (inExPstate0),
        .i_ex_pstate1  (inExPstate1),
        .o_src         (w_src),
        .o_target0     (w_tgt0),
        .o_target1     (w_tgt1),
        .o_flush_fd    (w_sel_flush_fd),
        .o_flush_of    (w_sel_flush_of)
    );

    assign w_any    = (w_src != SRC_NONE);
    assign w_active = (r_state == S_RUN) || (r_state == S_HALT);

    always_comb begin
        w_state_nxt = r_state;
        w_pc0_nxt   = r_pc0;
        w_pc1_nxt   = r_pc1;
        w_cnt_nxt   = r_cnt;
        w_valid     = 1'b0;
        w_halted    = 1'b0;
        w_flush_fd  = 1'b0;
        w_flush_of  = 1'b0;
        w_transfer  = 1'b0;

        case (r_state)
            S_RESET: w_state_nxt = S_RUN;
            S_RUN: begin
                w_valid = ~w_any;
                if (inHalt) w_state_nxt = S_HALT;
            end
            S_HALT: begin
                w_halted = 1'b1;
                if (!inHalt) w_state_nxt = S_RUN;
            end
            default: w_state_nxt = S_RESET;
        endcase

        w_transfer = (r_state == S_RUN) && w_valid && inFdReady;

        if (w_active) begin
            w_flush_fd = w_sel_flush_fd;
            w_flush_of = w_sel_flush_of;
            if (w_any) begin
                w_pc0_nxt = w_tgt0;
                w_pc1_nxt = w_tgt1;
                if (r_cnt != '1) w_cnt_nxt = r_cnt + CNT_WIDTH'(1);
            end else if (w_transfer) begin
                w_pc1_nxt = r_pc1 + WORD_LENGTH'(INSTR_BYTES);
            end
        end

        // Reset squashes every control output in the cycle it is asserted.
        if (rst) begin
            w_valid    = 1'b0;
            w_halted   = 1'b0;
            w_flush_fd = 1'b0;
            w_flush_of = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_RESET;
            r_pc0   <= RESET_PSTATE0;
            r_pc1   <= RESET_PSTATE1;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc0   <= w_pc0_nxt;
            r_pc1   <= w_pc1_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign outValid       = w_valid;
    assign outHalted      = w_halted;
    assign outFlushFd     = w_flush_fd;
    assign outFlushOf     = w_flush_of;
    assign outPstate0     = r_pc0;
    assign outPstate1     = r_pc1;
    assign outRedirectCnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_instr_adr_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_adr_seq
//  Description : Scoreboard bench for instr_adr_seq using directed vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_adr_seq;

    localparam logic [31:0] c_r0   = 32'hA5A5_0000;
    localparam logic [31:0] c_r1   = 32'h0000_0100;
    localparam logic [31:0] c_fd0  = 32'h1111_0000;
    localparam logic [31:0] c_of0  = 32'h2222_0000;
    localparam logic [31:0] c_ex0  = 32'h3333_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inHalt = 1'b0, inFdReady = 1'b0;
    logic        inFdRedirect = 1'b0, inOfRedirect = 1'b0, inExRedirect = 1'b0;
    logic [31:0] inFdPstate0 = c_fd0, inFdPstate1 = '0;
    logic [31:0] inOfPstate0 = c_of0, inOfPstate1 = '0;
    logic [31:0] inExPstate0 = c_ex0, inExPstate1 = '0;
    logic        outValid, outFlushFd, outFlushOf, outHalted;
    logic [31:0] outPstate0, outPstate1;
    logic [3:0]  outRedirectCnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic        v;
        logic [31:0] p0;
        logic [31:0] p1;
        logic        ffd;
        logic        fof;
        logic        hlt;
        logic [3:0]  cnt;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    instr_adr_seq #(
        .WORD_LENGTH   (32),
        .RESET_PSTATE0 (c_r0),
        .RESET_PSTATE1 (c_r1),
        .INSTR_BYTES   (4),
        .CNT_WIDTH     (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .inHalt         (inHalt),
        .inFdReady      (inFdReady),
        .inFdRedirect   (inFdRedirect),
        .inFdPstate0    (inFdPstate0),
        .inFdPstate1    (inFdPstate1),
        .inOfRedirect   (inOfRedirect),
        .inOfPstate0    (inOfPstate0),
        .inOfPstate1    (inOfPstate1),
        .inExRedirect   (inExRedirect),
        .inExPstate0    (inExPstate0),
        .inExPstate1    (inExPstate1),
        .outValid       (outValid),
        .outPstate0     (outPstate0),
        .outPstate1     (outPstate1),
        .outFlushFd     (outFlushFd),
        .outFlushOf     (outFlushOf),
        .outHalted      (outHalted),
        .outRedirectCnt (outRedirectCnt)
    );

    // Monitor: every cycle with a queued expectation is checked mid-cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (outValid !== e.v || outPstate0 !== e.p0 || outPstate1 !== e.p1 ||
                outFlushFd !== e.ffd || outFlushOf !== e.fof ||
                outHalted !== e.hlt || outRedirectCnt !== e.cnt) begin
                errors++;
                $display("FAIL %s: got v=%b p0=%h p1=%h ffd=%b fof=%b hlt=%b cnt=%h, expected v=%b p0=%h p1=%h ffd=%b fof=%b hlt=%b cnt=%h",
                         e.name, outValid, outPstate0, outPstate1, outFlushFd, outFlushOf,
                         outHalted, outRedirectCnt, e.v, e.p0, e.p1, e.ffd, e.fof, e.hlt, e.cnt);
            end
        end
    end

    task automatic cyc(input string nm, input logic r, input logic h, input logic rdy,
                       input logic fdr, input logic [31:0] fd1,
                       input logic ofr, input logic [31:0] of1,
                       input logic exr, input logic [31:0] ex1,
                       input logic ev, input logic [31:0] ep0, input logic [31:0] ep1,
                       input logic effd, input logic efof, input logic ehlt,
                       input logic [3:0] ecnt);
        exp_t e;
        @(posedge clk);
        #1;
        rst          = r;
        inHalt       = h;
        inFdReady    = rdy;
        inFdRedirect = fdr;
        inFdPstate1  = fd1;
        inOfRedirect = ofr;
        inOfPstate1  = of1;
        inExRedirect = exr;
        inExPstate1  = ex1;
        e.name = nm; e.v = ev; e.p0 = ep0; e.p1 = ep1;
        e.ffd = effd; e.fof = efof; e.hlt = ehlt; e.cnt = ecnt;
        sb.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //   name          rst h rdy fdr fd1       ofr of1       exr ex1          v  p0     p1            ffd fof hlt cnt
        cyc("reset",        1, 0, 0,  0, 0,        0, 0,        0, 0,           0, c_r0,  32'h100,       0, 0, 0, 4'd0);
        cyc("post_reset",   0, 0, 1,  0, 0,        0, 0,        0, 0,           0, c_r0,  32'h100,       0, 0, 0, 4'd0);
        cyc("run_100",      0, 0, 1,  0, 0,        0, 0,        0, 0,           1, c_r0,  32'h100,       0, 0, 0, 4'd0);
        cyc("run_104",      0, 0, 1,  0, 0,        0, 0,        0, 0,           1, c_r0,  32'h104,       0, 0, 0, 4'd0);
        cyc("run_108",      0, 0, 1,  0, 0,        0, 0,        0, 0,           1, c_r0,  32'h108,       0, 0, 0, 4'd0);
        cyc("fd_redir",     0, 0, 1,  1, 32'h200,  0, 0,        0, 0,           0, c_r0,  32'h10C,       0, 0, 0, 4'd0);
        cyc("bp_hold0",     0, 0, 0,  0, 0,        0, 0,        0, 0,           1, c_fd0, 32'h200,       0, 0, 0, 4'd1);
        cyc("bp_hold1",     0, 0, 0,  0, 0,        0, 0,        0, 0,           1, c_fd0, 32'h200,       0, 0, 0, 4'd1);
        cyc("bp_hold2",     0, 0, 0,  0, 0,        0, 0,        0, 0,           1, c_fd0, 32'h200,       0, 0, 0, 4'd1);
        cyc("bp_release",   0, 0, 1,  0, 0,        0, 0,        0, 0,           1, c_fd0, 32'h200,       0, 0, 0, 4'd1);
        cyc("bp_204",       0, 0, 1,  0, 0,        0, 0,        0, 0,           1, c_fd0, 32'h204,       0, 0, 0, 4'd1);
        cyc("prio_ex_fd",   0, 0, 1,  1, 32'h8000, 0, 0,        1, 32'h4000,    0, c_fd0, 32'h208,       1, 1, 0, 4'd1);
        cyc("prio_target",  0, 0, 1,  0, 0,        0, 0,        0, 0,           1, c_ex0, 32'h4000,      0, 0, 0, 4'd2);
        cyc("of_redir",     0, 0, 1,  0, 0,        1, 32'h1003, 0, 0,           0, c_ex0, 32'h4004,      1, 0, 0, 4'd2);
        cyc("of_aligned",   0, 0, 0,  0, 0,        0, 0,        0, 0,           1, c_of0, 32'h1000,      0, 0, 0, 4'd3);
        cyc("ex_to_top",    0, 0, 0,  0, 0,        0, 0,        1, 32'hFFFFFFFC,0, c_of0, 32'h1000,      1, 1, 0, 4'd3);
        cyc("wrap_pre",     0, 0, 1,  0, 0,        0, 0,        0, 0,           1, c_ex0, 32'hFFFFFFFC,  0, 0, 0, 4'd4);
        cyc("wrap_post",    0, 0, 0,  0, 0,        0, 0,        0, 0,           1, c_ex0, 32'h0,         0, 0, 0, 4'd4);
        cyc("halt_req",     0, 1, 1,  0, 0,        0, 0,        0, 0,           1, c_ex0, 32'h0,         0, 0, 0, 4'd4);
        cyc("halted",       0, 1, 1,  0, 0,        0, 0,        0, 0,           0, c_ex0, 32'h4,         0, 0, 1, 4'd4);
        cyc("halt_ex",      0, 1, 1,  0, 0,        0, 0,        1, 32'h500,     0, c_ex0, 32'h4,         1, 1, 1, 4'd4);
        cyc("halt_loaded",  0, 1, 1,  0, 0,        0, 0,        0, 0,           0, c_ex0, 32'h500,       0, 0, 1, 4'd5);
        cyc("halt_drop",    0, 0, 0,  0, 0,        0, 0,        0, 0,           0, c_ex0, 32'h500,       0, 0, 1, 4'd5);
        cyc("resume_500",   0, 0, 1,  0, 0,        0, 0,        0, 0,           1, c_ex0, 32'h500,       0, 0, 0, 4'd5);
        cyc("resume_504",   0, 0, 0,  0, 0,        0, 0,        0, 0,           1, c_ex0, 32'h504,       0, 0, 0, 4'd5);
        // Twenty back-to-back FD redirects drive the 4-bit counter into saturation.
        for (int i = 0; i < 20; i++) begin
            cyc("sat_redir", 0, 0, 1, 1, 32'h700, 0, 0, 0, 0,
                0, (i == 0) ? c_ex0 : c_fd0, (i == 0) ? 32'h504 : 32'h700,
                0, 0, 0, (5 + i > 15) ? 4'd15 : 4'(5 + i));
        end
        cyc("sat_final",    0, 0, 0,  0, 0,        0, 0,        0, 0,           1, c_fd0, 32'h700,       0, 0, 0, 4'd15);
        cyc("rst_with_ex",  1, 0, 1,  0, 0,        0, 0,        1, 32'h900,     0, c_fd0, 32'h700,       0, 0, 0, 4'd15);
        cyc("rst_ignore_ex",0, 0, 1,  0, 0,        0, 0,        1, 32'h900,     0, c_r0,  32'h100,       0, 0, 0, 4'd0);
        cyc("rerun_100",    0, 0, 1,  0, 0,        0, 0,        0, 0,           1, c_r0,  32'h100,       0, 0, 0, 4'd0);
        cyc("rerun_104",    0, 0, 0,  0, 0,        0, 0,        0, 0,           1, c_r0,  32'h104,       0, 0, 0, 4'd0);

        @(posedge clk);
        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expectations, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_adr_seq.md
Name: instr_adr_seq

Overview:
- Sequential next-instruction-address controller feeding the fetch/decode (FD) stage.
- Owns the architectural instruction address register pair (pstate0: status/segment word; pstate1: instruction offset).
- Advances the offset on each accepted fetch. Arbitrates redirect requests from FD, OF and EX with fixed priority, issues same-cycle flushes to younger stages, and supports halt.

Parameters:
- WORD_LENGTH, 32, width of pstate words.
- RESET_PSTATE0, 32'h0, pstate0 value after reset.
- RESET_PSTATE1, 32'h0, pstate1 (offset) value after reset.
- INSTR_BYTES, 4, offset increment per accepted instruction.
- CNT_WIDTH, 16, width of the redirect event counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- inHalt  in  1  request to stop issuing addresses.
- inFdReady  in  1  FD accepts the offered address this cycle.
- inFdRedirect  in  1  FD redirect (predicted branch).
- inFdPstate0 / inFdPstate1  in  WORD_LENGTH each  FD redirect target.
- inOfRedirect  in  1  OF redirect.
- inOfPstate0 / inOfPstate1  in  WORD_LENGTH each  OF redirect target.
- inExRedirect  in  1  EX redirect (resolved branch/trap).
- inExPstate0 / inExPstate1  in  WORD_LENGTH each  EX redirect target.
- outValid  out  1  outPstate0/1 is a valid fetch address this cycle.
- outPstate0 / outPstate1  out  WORD_LENGTH each  current instruction address.
- outFlushFd  out  1  kill the instruction in FD.
- outFlushOf  out  1  kill the instruction in OF.
- outHalted  out  1  sequencer is in S_HALT.
- outRedirectCnt  out  CNT_WIDTH  count of taken redirects, saturating.

Behaviour:
- Reset (rst=1 at edge), all registers:
  - pc0=RESET_PSTATE0, pc1=RESET_PSTATE1
  - state=S_RESET, counter=0
- Outputs during and directly after reset: outValid=0, outHalted=0, flushes=0. Reset mid-operation aborts everything, including a same-cycle redirect.
- States:
  - S_RESET: outValid=0. Next edge goes to S_RUN unconditionally; inHalt and redirects are ignored.
  - S_RUN: outValid = ~anyRedirect.
  - S_HALT: outValid=0, outHalted=1.
- Redirect selection is combinational, priority EX > OF > FD; only the winner is loaded, lower-priority requests in the same cycle are dropped. anyRedirect = OR of the three.
- Flushes are combinational in the redirect cycle, in any state except S_RESET:
  - EX redirect: outFlushFd=1, outFlushOf=1.
  - OF redirect: outFlushFd=1.
  - FD redirect: no flush.
- Transfer = state==S_RUN & outValid & inFdReady.
- Next-address rules (S_RUN or S_HALT):
  - Redirect wins: pc0<=target0 and pc1<=target1 with bits [1:0] forced to 0, regardless of inFdReady.
  - Otherwise, on transfer: pc1<=pc1+INSTR_BYTES, modulo 2^WORD_LENGTH (0xFFFFFFFC wraps to 0x0); pc0 unchanged.
  - Otherwise: hold both.
- Latency: a redirect target appears on outPstate the cycle after the request. There is no bubble beyond the discarded redirect-cycle address.
- Halt:
  - S_RUN & inHalt -> S_HALT. A same-cycle redirect is still loaded.
  - S_HALT & ~inHalt -> S_RUN.
  - Redirects in S_HALT load pc and flush but do not leave S_HALT.
- Counter: +1 on every edge with anyRedirect (state ≠ S_RESET); saturates at all-ones.
- outPstate0/1 are driven directly from pc0/pc1, so they are always visible, including while halted.

Decomposition:
- Shared package / defines.vh:
  - WORD_LENGTH
  - state enum {S_RESET, S_RUN, S_HALT} (2 bits)
  - redirect-source encoding {SRC_NONE, SRC_FD, SRC_OF, SRC_EX}
  - INSTR_BYTES constant
- One natural sub-module: instr_adr_sel, a purely combinational priority mux. It returns the winning source, target0/1 and the flush bits; the sequencer keeps all state.

Test Plan:
- Reset then run: rst 2 cycles with RESET_PSTATE1=0x100, inFdReady=1 -> outValid=0 in the first cycle after reset, then outPstate1=0x100, 0x104, 0x108 on consecutive cycles.
- Backpressure: inFdReady=0 for 3 cycles at pc1=0x200 -> pc1 holds 0x200 and outValid stays 1; pc1 goes to 0x204 after inFdReady returns to 1.
- Priority: EX (0x4000) and FD (0x8000) redirect in the same cycle -> outValid=0, outFlushFd=1, outFlushOf=1; next cycle pc1=0x4000; counter +1 only.
- Alignment/wrap: OF redirect to pc1=0x1003 -> pc1=0x1000 and outFlushOf=0; separately pc1=0xFFFFFFFC with a transfer -> pc1=0x0, pc0 unchanged.
- Halt: inHalt in S_RUN -> outHalted=1 and outValid=0; EX redirect to 0x500 while halted -> pc1=0x500, still halted; drop inHalt -> outValid=1 with 0x500.
- Saturation/reset: CNT_WIDTH=4 with 20 redirects -> outRedirectCnt=0xF; rst in a cycle with an active EX redirect -> pc1=RESET_PSTATE1 and counter=0.
